i2s_tx_sequencer: RTL and testbench



---
 rtl/i2s_tx_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_i2s_tx_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: sample FIFO plus a frame-aware bit scheduler.
// L/R words are popped at fixed slot positions; a short FIFO mutes the frame.
module i2s_tx_sequencer #(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LOW_WATER  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [SAMPLE_W-1:0]         in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        bclk,
    output logic                        lr_clk,
    output logic                        serial,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        irq,
    output logic                        underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] BIT_R    = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] LR_LO    = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] LR_HI    = BIT_W'(2 * SLOT_W - 2);
    localparam logic [BIT_W-1:0] L_LO     = BIT_W'(1);
    localparam logic [BIT_W-1:0] L_HI     = BIT_W'(SAMPLE_W);
    localparam logic [BIT_W-1:0] R_LO     = BIT_W'(SLOT_W + 1);
    localparam logic [BIT_W-1:0] R_HI     = BIT_W'(SLOT_W + SAMPLE_W);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(LOW_WATER);
    localparam logic [LVL_W-1:0] LVL_PAIR = LVL_W'(2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;

    logic [SAMPLE_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [SAMPLE_W-1:0]  sreg_q, sreg_d;
    logic                 live_q, live_d;
    logic                 bclk_q, bclk_d;
    logic                 lr_q, lr_d;
    logic                 ser_q, ser_d;
    logic                 irq_q, irq_d;
    logic                 under_q, under_d;

    logic                 run;
    logic                 wrap;
    logic                 fetch_l;
    logic                 fetch_r;
    logic                 can_l;
    logic                 push;
    logic                 pop;
    logic                 data_bit;
    logic [SAMPLE_W-1:0]  fifo_rd;

    assign run      = (state_q == RUN);
    assign wrap     = run && (div_q == DIV_LAST);
    assign fetch_l  = run && (div_q == '0) && (bit_q == '0);
    assign fetch_r  = run && (div_q == '0) && (bit_q == BIT_R);
    assign can_l    = (level_q >= LVL_PAIR);
    assign in_ready = (level_q < LVL_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (fetch_l && can_l) || (fetch_r && live_q);
    assign fifo_rd  = mem_q[rptr_q];
    assign level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

    // Bit positions that carry sample data, judged on the upcoming bit.
    assign data_bit = ((bit_d >= L_LO) && (bit_d <= L_HI)) ||
                      ((bit_d >= R_LO) && (bit_d <= R_HI));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (!enable) begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bclk_d  = (state_d == RUN) && (div_d >= DIV_HALF);
        lr_d    = (state_d == RUN) && (bit_d >= LR_LO) && (bit_d <= LR_HI);
        irq_d   = run && (level_q <= LVL_LOW);
        ser_d   = ser_q;
        sreg_d  = sreg_q;
        live_d  = live_q;
        under_d = under_q;

        if (state_d != RUN) begin
            ser_d = 1'b0;
        end else if (wrap) begin
            ser_d = data_bit ? sreg_q[SAMPLE_W-1] : 1'b0;
        end

        if (fetch_l) begin
            sreg_d = can_l ? fifo_rd : '0;
            live_d = can_l;
            if (!can_l) begin
                under_d = 1'b1;
            end
        end else if (fetch_r) begin
            sreg_d = live_q ? fifo_rd : '0;
        end else if (wrap && data_bit) begin
            sreg_d = {sreg_q[SAMPLE_W-2:0], 1'b0};
        end

        if (!run && enable) begin
            under_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            sreg_q  <= '0;
            live_q  <= 1'b0;
            bclk_q  <= 1'b0;
            lr_q    <= 1'b0;
            ser_q   <= 1'b0;
            irq_q   <= 1'b0;
            under_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            level_q <= level_d;
            sreg_q  <= sreg_d;
            live_q  <= live_d;
            bclk_q  <= bclk_d;
            lr_q    <= lr_d;
            ser_q   <= ser_d;
            irq_q   <= irq_d;
            under_q <= under_d;
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    assign bclk       = bclk_q;
    assign lr_clk     = lr_q;
    assign serial     = ser_q;
    assign fifo_level = level_q;
    assign irq        = irq_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: vector table, directed frames and a random run
// compared cycle by cycle against a frame-arithmetic reference model.
module tb_i2s_tx_sequencer;

    localparam int SW    = 24;
    localparam int SLOT  = 32;
    localparam int DIV   = 4;
    localparam int DEP   = 4;
    localparam int LW    = 1;
    localparam int NBIT  = 2 * SLOT;
    localparam int FRAME = NBIT * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          in_valid = 1'b0;
    logic [SW-1:0] in_data = '0;
    logic          in_ready, bclk, lr_clk, serial, irq, underrun;
    logic [2:0]    fifo_level;

    always #5 clk = ~clk;

    i2s_tx_sequencer #(
        .SAMPLE_W  (SW),
        .SLOT_W    (SLOT),
        .BCLK_DIV  (DIV),
        .FIFO_DEPTH(DEP),
        .LOW_WATER (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bclk      (bclk),
        .lr_clk    (lr_clk),
        .serial    (serial),
        .fifo_level(fifo_level),
        .irq       (irq),
        .underrun  (underrun)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: time since RUN entry fixes the bit position.
    bit            m_run = 0;
    int            m_t = 0;
    logic [SW-1:0] m_q[$];
    bit            m_live = 0, m_under = 0, m_irq = 0;
    logic [SW-1:0] m_l = '0, m_r = '0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic r, e, v, input logic [SW-1:0] d);
        int  lvl, cnt, b;
        bit  irq_n;
        if (r) begin
            m_run = 0; m_t = 0; m_q.delete();
            m_live = 0; m_under = 0; m_irq = 0; m_l = '0; m_r = '0;
            return;
        end
        lvl   = m_q.size();
        irq_n = m_run && (lvl <= LW);
        if (m_run) begin
            cnt = m_t % DIV;
            b   = (m_t / DIV) % NBIT;
            if (cnt == 0 && b == 0) begin
                if (lvl >= 2) begin
                    m_l = m_q.pop_front(); m_live = 1;
                end else begin
                    m_l = '0; m_r = '0; m_live = 0; m_under = 1;
                end
            end
            if (cnt == 0 && b == SLOT && m_live) m_r = m_q.pop_front();
        end
        if (v && lvl < DEP) m_q.push_back(d);
        m_irq = irq_n;
        if (!m_run) begin
            if (e) begin m_run = 1; m_t = 0; m_under = 0; end
        end else if ((m_t % FRAME) == FRAME - 1 && !e) begin
            m_run = 0;
        end else begin
            m_t++;
        end
    endtask

    function automatic logic [8:0] model_out();
        logic bc = 0, lr = 0, sd = 0;
        int   cnt, b, lvl;
        if (m_run) begin
            cnt = m_t % DIV;
            b   = (m_t / DIV) % NBIT;
            bc  = (cnt >= DIV / 2);
            lr  = (b >= SLOT - 1) && (b <= NBIT - 2);
            if (b >= 1 && b <= SW) sd = m_l[SW-b];
            else if (b >= SLOT + 1 && b <= SLOT + SW) sd = m_r[SLOT+SW-b];
        end
        lvl = m_q.size();
        return {bc, lr, sd, m_irq, m_under, (lvl < DEP), 3'(lvl)};
    endfunction

    task automatic tick(input logic r, e, v, input logic [SW-1:0] d);
        rst = r; enable = e; in_valid = v; in_data = d;
        @(posedge clk);
        model_step(r, e, v, d);
        @(negedge clk);
        check("model", {23'd0, bclk, lr_clk, serial, irq, underrun,
                        in_ready, fifo_level}, {23'd0, model_out()});
    endtask

    logic          sbit[NBIT];
    logic          lbit[NBIT];
    logic [SW-1:0] f_l, f_r;
    logic          f_or, f_irq0, f_irq1, f_un1;
    logic [2:0]    f_lv1, f_lv2;

    task automatic sample(input int t);
        if (t % DIV == 0) begin
            sbit[t/DIV] = serial;
            lbit[t/DIV] = lr_clk;
            f_or = f_or | serial;
        end
        if (t == 0) f_irq0 = irq;
        if (t == 1) begin f_irq1 = irq; f_un1 = underrun; end
        if (t == DIV) f_lv1 = fifo_level;
        if (t == (SLOT + 1) * DIV) f_lv2 = fifo_level;
    endtask

    // Enable one frame, drop enable at drop_t, decode what was shifted out.
    task automatic play_frame(input int drop_t);
        f_or = 0;
        tick(0, 1, 0, '0);
        sample(0);
        for (int t = 1; t < FRAME; t++) begin
            tick(0, t < drop_t, 0, '0);
            sample(t);
        end
        tick(0, 0, 0, '0);
        for (int i = 0; i < SW; i++) begin
            f_l[SW-1-i] = sbit[1+i];
            f_r[SW-1-i] = sbit[SLOT+1+i];
        end
    endtask

    typedef struct {
        logic          r, e, v;
        logic [SW-1:0] d;
        logic [2:0]    lvl;
        logic          rdy;
        logic [4:0]    misc;
    } vec_t;

    vec_t vt[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        int rates[4];
        vt[0] = '{1, 0, 0, 24'h000000, 3'd0, 1'b1, 5'b0};
        vt[1] = '{1, 0, 0, 24'h000000, 3'd0, 1'b1, 5'b0};
        vt[2] = '{0, 0, 1, 24'h0A0001, 3'd1, 1'b1, 5'b0};
        vt[3] = '{0, 0, 1, 24'h0B0002, 3'd2, 1'b1, 5'b0};
        vt[4] = '{0, 0, 1, 24'h0A0003, 3'd3, 1'b1, 5'b0};
        vt[5] = '{0, 0, 1, 24'h0B0004, 3'd4, 1'b0, 5'b0};
        vt[6] = '{0, 0, 1, 24'h0E0005, 3'd4, 1'b0, 5'b0};
        vt[7] = '{0, 0, 0, 24'h000000, 3'd4, 1'b0, 5'b0};
        rates = '{500, 8, 4, 200};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tick(vt[i].r, vt[i].e, vt[i].v, vt[i].d);
            check("vec_level", 32'(fifo_level), 32'(vt[i].lvl));
            check("vec_ready", 32'(in_ready), 32'(vt[i].rdy));
            check("vec_outs", 32'({bclk, lr_clk, serial, irq, underrun}),
                  32'(vt[i].misc));
        end

        // Pop while full with in_valid held: 4 -> 3 -> 4.
        tick(0, 1, 1, 24'h111111);
        check("full_enter", 32'(fifo_level), 32'd4);
        tick(0, 1, 1, 24'h222222);
        check("full_pop", 32'(fifo_level), 32'd3);
        tick(0, 1, 1, 24'h333333);
        check("full_refill", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 3 * FRAME && m_run; i++) tick(0, 0, 0, '0);
        check("drain_idle", 32'({bclk, lr_clk, serial}), 32'd0);

        // Live frame with known words.
        tick(1, 0, 0, '0);
        tick(1, 0, 0, '0);
        tick(0, 0, 1, 24'hABCDEF);
        tick(0, 0, 1, 24'h123456);
        play_frame(40);
        check("left_word", 32'(f_l), 32'hABCDEF);
        check("right_word", 32'(f_r), 32'h123456);
        check("lr_edges", 32'({lbit[30], lbit[31], lbit[62], lbit[63]}),
              32'b0110);
        check("level_after_l", 32'(f_lv1), 32'd1);
        check("level_after_r", 32'(f_lv2), 32'd0);
        check("live_no_underrun", 32'(f_un1), 32'd0);

        // One word only: the frame is muted and nothing is popped.
        tick(1, 0, 0, '0);
        tick(0, 0, 1, 24'h5A5A5A);
        play_frame(40);
        check("mute_serial", 32'(f_or), 32'd0);
        check("mute_underrun", 32'(f_un1), 32'd1);
        check("irq_latency0", 32'(f_irq0), 32'd0);
        check("irq_latency1", 32'(f_irq1), 32'd1);
        check("mute_level", 32'(fifo_level), 32'd1);

        // Enable drops at bit 10; the frame still completes, then stops.
        tick(1, 0, 0, '0);
        tick(0, 0, 1, 24'hC00001);
        tick(0, 0, 1, 24'hD00002);
        tick(0, 0, 1, 24'hC00003);
        tick(0, 0, 1, 24'hD00004);
        play_frame(10 * DIV);
        check("drop_left", 32'(f_l), 32'hC00001);
        check("drop_right", 32'(f_r), 32'hD00002);
        for (int i = 0; i < 50; i++) tick(0, 0, 0, '0);
        check("drop_level", 32'(fifo_level), 32'd2);
        check("drop_quiet", 32'({bclk, lr_clk, serial}), 32'd0);

        // Reset at bit 20 with three words queued.
        tick(1, 0, 0, '0);
        tick(0, 0, 1, 24'h777777);
        tick(0, 0, 1, 24'h888888);
        tick(0, 0, 1, 24'h999999);
        tick(0, 1, 0, '0);
        for (int t = 1; t <= 20 * DIV; t++) tick(0, 1, 0, '0);
        tick(1, 1, 0, '0);
        check("rst_outs", 32'({bclk, lr_clk, serial, irq, underrun}), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        tick(0, 0, 1, 24'h0F1E2D);
        tick(0, 0, 1, 24'h3C4B5A);
        play_frame(40);
        check("rerun_left", 32'(f_l), 32'h0F1E2D);
        check("rerun_right", 32'(f_r), 32'h3C4B5A);

        // Random traffic at several fill rates, checked every cycle.
        tick(1, 0, 0, '0);
        for (int ph = 0; ph < 4; ph++) begin
            p = rates[ph];
            for (int i = 0; i < 1200; i++) begin
                tick($urandom_range(0, 999) == 0,
                     $urandom_range(0, 99) < 96,
                     $urandom_range(0, 999) < p,
                     24'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
